// File: rtl/output_buffer_if.sv
// Handshake bundle for output_buffer: core-side write port and host-side read port.
interface output_buffer_if #(
  parameter int RESULT_SIZE   = 144,
  parameter int OBUFFER_DEPTH = 20
);
  localparam int CNT_W = $clog2(OBUFFER_DEPTH + 2);

  logic                   valid_in;
  logic [RESULT_SIZE-1:0] data_in;
  logic                   ready_out;
  logic                   almost_full;
  logic                   valid_out;
  logic [RESULT_SIZE-1:0] data_out;
  logic                   ready_in;
  logic [CNT_W-1:0]       count;

  modport slave (
    input  valid_in, data_in, ready_in,
    output ready_out, almost_full, valid_out, data_out, count
  );

  modport master (
    output valid_in, data_in, ready_in,
    input  ready_out, almost_full, valid_out, data_out, count
  );
endinterface

// File: rtl/output_buffer.sv
// Result FIFO: circular storage of OBUFFER_DEPTH words drained through a registered FWFT output stage.
// Optional OBUF_OVERFLOW_CNT_EN adds overflow_cnt/overflow_sticky for dropped writes.
module output_buffer #(
  parameter int OBUFFER_DEPTH      = 20,
  parameter int RESULT_SIZE        = 144,
  parameter int ALMOST_FULL_THRESH = 4
) (
  input logic             clk,
  input logic             rst,
  output_buffer_if.slave  bus
`ifdef OBUF_OVERFLOW_CNT_EN
  ,
  output logic [15:0]     overflow_cnt,
  output logic            overflow_sticky
`endif
);

  localparam int PTR_W = $clog2(OBUFFER_DEPTH);
  localparam int OCC_W = $clog2(OBUFFER_DEPTH + 1);
  localparam int CNT_W = $clog2(OBUFFER_DEPTH + 2);
  localparam int AF_MIN = (ALMOST_FULL_THRESH >= OBUFFER_DEPTH) ? 0 : OBUFFER_DEPTH - ALMOST_FULL_THRESH;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OBUFFER_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(OBUFFER_DEPTH);
  localparam logic [OCC_W-1:0] OCC_AF   = OCC_W'(AF_MIN);

  typedef enum logic [1:0] {O_EMPTY, O_FETCH, O_VALID} ostate_e;

  logic [RESULT_SIZE-1:0] mem_q [OBUFFER_DEPTH];

  ostate_e                state_q, state_d;
  logic [PTR_W-1:0]       wptr_q, wptr_d;
  logic [PTR_W-1:0]       rptr_q, rptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   valid_out_q, valid_out_d;
  logic [RESULT_SIZE-1:0] data_out_q, data_out_d;
  logic [RESULT_SIZE-1:0] rd_data_q, rd_data_d;

  logic ready_out;
  logic wr_en;
  logic rd_en;
  logic pop;

  // Occupancy tracks storage only; the word in flight or in data_out is not included.
  assign ready_out       = (occ_q < OCC_FULL);
  assign bus.ready_out   = ready_out;
  assign bus.almost_full = (occ_q >= OCC_AF);
  assign bus.valid_out   = valid_out_q;
  assign bus.data_out    = data_out_q;
  assign bus.count       = count_q;

  always_comb begin
    wr_en       = bus.valid_in && ready_out;
    pop         = valid_out_q && bus.ready_in;
    rd_en       = 1'b0;
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    rd_data_d   = rd_data_q;

    case (state_q)
      O_EMPTY: begin
        if (occ_q != '0) begin
          rd_en   = 1'b1;
          state_d = O_FETCH;
        end
      end
      O_FETCH: begin
        data_out_d  = rd_data_q;
        valid_out_d = 1'b1;
        state_d     = O_VALID;
      end
      O_VALID: begin
        if (pop) begin
          valid_out_d = 1'b0;
          if (occ_q != '0) begin
            rd_en   = 1'b1;
            state_d = O_FETCH;
          end else begin
            state_d = O_EMPTY;
          end
        end
      end
      default: state_d = O_EMPTY;
    endcase

    if (rd_en) begin
      rd_data_d = mem_q[rptr_q];
      rptr_d    = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
    end
    if (wr_en) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
    end

    occ_d   = occ_q + OCC_W'(wr_en) - OCC_W'(rd_en);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= O_EMPTY;
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= '0;
      count_q     <= '0;
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      count_q     <= count_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= bus.data_in;
    end
  end

`ifdef OBUF_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_sticky_q, ovf_sticky_d;
  logic        drop;

  always_comb begin
    drop         = bus.valid_in && !ready_out;
    ovf_cnt_d    = ovf_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    if (drop) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q    <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_cnt_q    <= ovf_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign overflow_cnt    = ovf_cnt_q;
  assign overflow_sticky = ovf_sticky_q;
`endif

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: queue-based reference model compared every cycle, plus directed literal checks.
module tb_output_buffer;
  localparam int DEPTH = 20;
  localparam int RS    = 144;
  localparam int TH    = 4;
  localparam int CW    = $clog2(DEPTH + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_buffer_if #(.RESULT_SIZE(RS), .OBUFFER_DEPTH(DEPTH)) bus ();

`ifdef OBUF_OVERFLOW_CNT_EN
  logic [15:0] ovf_cnt;
  logic        ovf_sticky;
`endif

  output_buffer #(
    .OBUFFER_DEPTH(DEPTH),
    .RESULT_SIZE(RS),
    .ALMOST_FULL_THRESH(TH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef OBUF_OVERFLOW_CNT_EN
    ,
    .overflow_cnt(ovf_cnt),
    .overflow_sticky(ovf_sticky)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_pops = 0;

  task automatic chk(string name, logic [RS-1:0] act, logic [RS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage as a queue, one word in flight, one output slot.
  logic [RS-1:0] m_store[$];
  logic [RS-1:0] sb[$];
  bit            m_pend;
  logic [RS-1:0] m_pend_d;
  bit            m_val;
  logic [RS-1:0] m_dat;
  bit            m_pop, m_wr, m_fetch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_store.delete();
      sb.delete();
      m_pend = 1'b0;
      m_val  = 1'b0;
      m_dat  = '0;
    end else begin
      m_pop   = m_val && (bus.ready_in === 1'b1);
      m_wr    = (bus.valid_in === 1'b1) && (m_store.size() < DEPTH);
      m_fetch = ((!m_val && !m_pend) || m_pop) && (m_store.size() > 0);
      if (m_pend) begin
        m_val  = 1'b1;
        m_dat  = m_pend_d;
        m_pend = 1'b0;
      end else if (m_pop) begin
        m_val = 1'b0;
      end
      if (m_fetch) begin
        m_pend_d = m_store.pop_front();
        m_pend   = 1'b1;
      end
      if (m_wr) begin
        m_store.push_back(bus.data_in);
        sb.push_back(bus.data_in);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out", RS'(bus.valid_out), RS'(m_val));
      if (m_val) chk("data_out", bus.data_out, m_dat);
      chk("ready_out", RS'(bus.ready_out), RS'(m_store.size() < DEPTH));
      chk("almost_full", RS'(bus.almost_full), RS'((DEPTH - m_store.size()) <= TH));
      chk("count", RS'(bus.count), RS'(m_store.size() + int'(m_pend) + int'(m_val)));
      if (bus.valid_out && bus.ready_in) begin
        n_pops++;
        if (sb.size() == 0) chk("order_underflow", RS'(1), RS'(0));
        else chk("order", bus.data_out, sb.pop_front());
      end
    end
  end

  task automatic drive(bit v, logic [RS-1:0] d, bit r);
    bus.valid_in = v;
    bus.data_in  = d;
    bus.ready_in = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RS-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[RS-1:0];
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int guard;
    bit tog;

    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    chk("rst_valid_out", RS'(bus.valid_out), RS'(0));
    chk("rst_count", RS'(bus.count), RS'(0));
    chk("rst_ready_out", RS'(bus.ready_out), RS'(1));
    chk("rst_almost_full", RS'(bus.almost_full), RS'(0));
    chk("rst_data_out", bus.data_out, RS'(0));
    rst = 1'b0;
    tick();

    // First-word latency
    drive(1'b1, RS'('hA1), 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    chk("lat_e1_valid", RS'(bus.valid_out), RS'(0));
    tick();
    chk("lat_e2_valid", RS'(bus.valid_out), RS'(1));
    chk("lat_e2_data", bus.data_out, RS'('hA1));
    tick();
    chk("lat_e3_valid", RS'(bus.valid_out), RS'(0));
    chk("lat_e3_count", RS'(bus.count), RS'(0));

    // Fill: 21 words accepted with output stalled
    for (int i = 1; i <= 21; i++) begin
      drive(1'b1, RS'(i), 1'b0);
      tick();
    end
    chk("fill_count", RS'(bus.count), RS'(21));
    chk("fill_ready_out", RS'(bus.ready_out), RS'(0));
    chk("fill_almost_full", RS'(bus.almost_full), RS'(1));
    chk("fill_head", bus.data_out, RS'(1));
    drive(1'b1, RS'(22), 1'b0);
    tick();
    chk("drop_count", RS'(bus.count), RS'(21));
`ifdef OBUF_OVERFLOW_CNT_EN
    chk("ovf_cnt", RS'(ovf_cnt), RS'(1));
`endif
    // Full storage with simultaneous write and pop: write refused
    drive(1'b1, RS'(23), 1'b1);
    tick();
    chk("fullpop_count", RS'(bus.count), RS'(20));
    chk("fullpop_ready_out", RS'(bus.ready_out), RS'(1));
    drive(1'b0, '0, 1'b1);
    repeat (50) tick();
    chk("drain_count", RS'(bus.count), RS'(0));

    // Backpressure hold
    drive(1'b1, RS'('h55), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", RS'(bus.valid_out), RS'(1));
      chk("hold_data", bus.data_out, RS'('h55));
      tick();
    end
    drive(1'b0, '0, 1'b1);
    tick();
    chk("hold_popped", RS'(bus.valid_out), RS'(0));
    chk("hold_count", RS'(bus.count), RS'(0));

    // Ordering across wrap with toggling drain
    n_pops = 0;
    n = 0;
    tog = 1'b1;
    guard = 0;
    while (n < 30 && guard < 1000) begin
      if (bus.ready_out) begin
        drive(1'b1, RS'(n + 1), tog);
        n++;
      end else begin
        drive(1'b0, '0, tog);
      end
      tog = ~tog;
      guard++;
      tick();
    end
    drive(1'b0, '0, 1'b1);
    repeat (80) tick();
    chk("wrap_pops", RS'(n_pops), RS'(30));
    chk("wrap_count", RS'(bus.count), RS'(0));

    // Randomized traffic with phases of heavy and light drain
    for (int i = 0; i < 600; i++) begin
      int rpct;
      rpct = (i % 200 < 100) ? 20 : 80;
      drive(bit'($urandom_range(0, 99) < 60), rnd_word(), bit'($urandom_range(0, 99) < rpct));
      tick();
    end
    drive(1'b0, '0, 1'b1);
    repeat (60) tick();
    chk("rand_count", RS'(bus.count), RS'(0));

    // Asynchronous reset mid-drain
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, RS'('h300 + i), 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    chk("pre_rst_count", RS'(bus.count), RS'(7));
    drive(1'b0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", RS'(bus.valid_out), RS'(0));
    chk("arst_count", RS'(bus.count), RS'(0));
    chk("arst_data", bus.data_out, RS'(0));
    chk("arst_ready_out", RS'(bus.ready_out), RS'(1));
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, RS'('hBEEF), 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    repeat (2) tick();
    chk("post_rst_head", bus.data_out, RS'('hBEEF));
    chk("post_rst_count", RS'(bus.count), RS'(1));
    drive(1'b0, '0, 1'b1);
    repeat (3) tick();
    chk("post_rst_drained", RS'(bus.count), RS'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
